// File: rtl/regfile_wb_scheduler_if.sv
// Writeback request channels (DBG, ALU, MEM) toward the register-file write scheduler.
interface regfile_wb_scheduler_if #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 32
);
    logic          dbg_valid;
    logic [AW-1:0] dbg_rd;
    logic [DW-1:0] dbg_wd;
    logic          dbg_ready;

    logic          alu_valid;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_wd;
    logic          alu_ready;

    logic          mem_valid;
    logic [AW-1:0] mem_rd;
    logic [DW-1:0] mem_wd;
    logic          mem_ready;

    // Requesting side: the writeback sources.
    modport master (
        output dbg_valid, dbg_rd, dbg_wd,
        output alu_valid, alu_rd, alu_wd,
        output mem_valid, mem_rd, mem_wd,
        input  dbg_ready, alu_ready, mem_ready
    );

    // Accepting side: the scheduler.
    modport slave (
        input  dbg_valid, dbg_rd, dbg_wd,
        input  alu_valid, alu_rd, alu_wd,
        input  mem_valid, mem_rd, mem_wd,
        output dbg_ready, alu_ready, mem_ready
    );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port arbiter (DBG fixed priority, ALU/MEM round-robin)
// with a per-register pending-write scoreboard for issue-stage hazards.
module regfile_wb_scheduler #(
    parameter int unsigned AW   = 4,
    parameter int unsigned DW   = 32,
    parameter int unsigned NREG = 2**AW
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_scheduler_if.slave wb,
    input  logic                 issue_valid,
    input  logic [AW-1:0]        issue_rd,
    output logic                 issue_stall,
    input  logic [AW-1:0]        chk_rs1,
    input  logic [AW-1:0]        chk_rs2,
    input  logic [AW-1:0]        chk_rs3,
    output logic                 hazard,
    output logic                 rf_wr_enable,
    output logic [AW-1:0]        rf_rd,
    output logic [DW-1:0]        rf_wd,
    output logic [NREG-1:0]      busy_mask,
    output logic                 sb_error
);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DBG  = 2'd1,
        TAG_ALU  = 2'd2,
        TAG_MEM  = 2'd3
    } src_tag_t;

    src_tag_t      src_tag;
    logic          rr_mem_first;
    logic [1:0]    pend     [NREG];
    logic [1:0]    pend_nxt [NREG];
    logic          underflow;

    logic          gnt_dbg;
    logic          gnt_alu;
    logic          gnt_mem;
    logic [AW-1:0] sel_rd;
    logic [DW-1:0] sel_wd;
    logic          dec_en;
    logic          inc_en;

    // Grant selection: DBG always wins, ALU/MEM tie broken by the round-robin pointer.
    always_comb begin
        gnt_dbg = 1'b0;
        gnt_alu = 1'b0;
        gnt_mem = 1'b0;
        if (!rst) begin
            if (wb.dbg_valid) begin
                gnt_dbg = 1'b1;
            end else if (wb.alu_valid && (!wb.mem_valid || !rr_mem_first)) begin
                gnt_alu = 1'b1;
            end else if (wb.mem_valid) begin
                gnt_mem = 1'b1;
            end
        end
    end

    assign wb.dbg_ready = gnt_dbg;
    assign wb.alu_ready = gnt_alu;
    assign wb.mem_ready = gnt_mem;

    // Payload mux for the granted source.
    always_comb begin
        sel_rd = wb.mem_rd;
        sel_wd = wb.mem_wd;
        if (gnt_dbg) begin
            sel_rd = wb.dbg_rd;
            sel_wd = wb.dbg_wd;
        end else if (gnt_alu) begin
            sel_rd = wb.alu_rd;
            sel_wd = wb.alu_wd;
        end
    end

    // A non-debug write retires a pending entry at the end of its write cycle.
    assign dec_en      = rf_wr_enable && (src_tag == TAG_ALU || src_tag == TAG_MEM);
    assign issue_stall = (pend[issue_rd] == 2'd3) && !(dec_en && (rf_rd == issue_rd));
    assign inc_en      = issue_valid && !issue_stall;

    // Next scoreboard state; simultaneous issue and retire on one register cancel out.
    always_comb begin
        underflow = 1'b0;
        for (int r = 0; r < int'(NREG); r++) begin
            pend_nxt[r] = pend[r];
            if (inc_en && (issue_rd == AW'(r)) && !(dec_en && (rf_rd == AW'(r)))) begin
                pend_nxt[r] = pend[r] + 2'd1;
            end else if (dec_en && (rf_rd == AW'(r)) && !(inc_en && (issue_rd == AW'(r)))) begin
                if (pend[r] == 2'd0) begin
                    underflow = 1'b1;
                end else begin
                    pend_nxt[r] = pend[r] - 2'd1;
                end
            end
        end
    end

    // Busy bits follow the pending counters directly.
    always_comb begin
        busy_mask = '0;
        for (int r = 0; r < int'(NREG); r++) begin
            busy_mask[r] = (pend[r] != 2'd0);
        end
    end

    // Read hazard for the instruction in decode.
    assign hazard = busy_mask[chk_rs1] | busy_mask[chk_rs2] | busy_mask[chk_rs3];

    // Write port, round-robin pointer and scoreboard registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wr_enable <= 1'b0;
            rf_rd        <= '0;
            rf_wd        <= '0;
            src_tag      <= TAG_NONE;
            rr_mem_first <= 1'b0;
            sb_error     <= 1'b0;
            for (int r = 0; r < int'(NREG); r++) begin
                pend[r] <= 2'd0;
            end
        end else begin
            rf_wr_enable <= gnt_dbg | gnt_alu | gnt_mem;
            src_tag      <= TAG_NONE;
            if (gnt_dbg | gnt_alu | gnt_mem) begin
                rf_rd <= sel_rd;
                rf_wd <= sel_wd;
            end
            if (gnt_dbg) begin
                src_tag <= TAG_DBG;
            end else if (gnt_alu) begin
                src_tag      <= TAG_ALU;
                rr_mem_first <= 1'b1;
            end else if (gnt_mem) begin
                src_tag      <= TAG_MEM;
                rr_mem_first <= 1'b0;
            end
            sb_error <= sb_error | underflow;
            for (int r = 0; r < int'(NREG); r++) begin
                pend[r] <= pend_nxt[r];
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench: directed stimulus with a write-port scoreboard queue.
module tb_regfile_wb_scheduler;

    localparam int unsigned AW   = 4;
    localparam int unsigned DW   = 32;
    localparam int unsigned NREG = 16;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] wd;
    } wr_t;

    logic            clk;
    logic            rst;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic            issue_stall;
    logic [AW-1:0]   chk_rs1;
    logic [AW-1:0]   chk_rs2;
    logic [AW-1:0]   chk_rs3;
    logic            hazard;
    logic            rf_wr_enable;
    logic [AW-1:0]   rf_rd;
    logic [DW-1:0]   rf_wd;
    logic [NREG-1:0] busy_mask;
    logic            sb_error;

    int  errors = 0;
    int  checks = 0;
    wr_t exp_q[$];

    regfile_wb_scheduler_if #(.AW(AW), .DW(DW)) wb_bus ();

    regfile_wb_scheduler #(.AW(AW), .DW(DW), .NREG(NREG)) dut (
        .clk          (clk),
        .rst          (rst),
        .wb           (wb_bus.slave),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_stall  (issue_stall),
        .chk_rs1      (chk_rs1),
        .chk_rs2      (chk_rs2),
        .chk_rs3      (chk_rs3),
        .hazard       (hazard),
        .rf_wr_enable (rf_wr_enable),
        .rf_rd        (rf_rd),
        .rf_wd        (rf_wd),
        .busy_mask    (busy_mask),
        .sb_error     (sb_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_ready(input string name, input logic d, input logic a, input logic m);
        chk({name, " ready"}, 32'({wb_bus.dbg_ready, wb_bus.alu_ready, wb_bus.mem_ready}),
            32'({d, a, m}));
    endtask

    task automatic push(input logic [AW-1:0] rd, input logic [DW-1:0] wd);
        wr_t e;
        e.rd = rd;
        e.wd = wd;
        exp_q.push_back(e);
    endtask

    // Starts at a falling edge, issues one instruction, ends at the next falling edge.
    task automatic do_issue(input logic [AW-1:0] rd);
        issue_valid = 1'b1;
        issue_rd    = rd;
        #1;
        chk("issue_stall_free", 32'(issue_stall), 32'h0);
        @(negedge clk);
        issue_valid = 1'b0;
    endtask

    // Monitor: every register-file write must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && rf_wr_enable) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got rd=%0d wd=0x%0h expected none", rf_rd, rf_wd);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("rf_rd", 32'(rf_rd), 32'(e.rd));
                chk("rf_wd", rf_wd, e.wd);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        issue_valid = 1'b0; issue_rd = '0;
        chk_rs1 = '0; chk_rs2 = '0; chk_rs3 = '0;
        wb_bus.dbg_valid = 1'b0; wb_bus.dbg_rd = '0; wb_bus.dbg_wd = '0;
        wb_bus.alu_valid = 1'b0; wb_bus.alu_rd = '0; wb_bus.alu_wd = '0;
        wb_bus.mem_valid = 1'b0; wb_bus.mem_rd = '0; wb_bus.mem_wd = '0;
        #1 rst = 1'b1;
        wb_bus.dbg_valid = 1'b1; wb_bus.alu_valid = 1'b1; wb_bus.mem_valid = 1'b1;
        #1;
        chk_ready("in_reset", 1'b0, 1'b0, 1'b0);
        chk("rst_wr_enable", 32'(rf_wr_enable), 32'h0);
        chk("rst_rf_rd", 32'(rf_rd), 32'h0);
        chk("rst_rf_wd", rf_wd, 32'h0);
        chk("rst_busy", 32'(busy_mask), 32'h0);
        chk("rst_sb_error", 32'(sb_error), 32'h0);
        chk("rst_hazard", 32'(hazard), 32'h0);
        @(negedge clk);
        wb_bus.dbg_valid = 1'b0; wb_bus.alu_valid = 1'b0; wb_bus.mem_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Preload pending writes for the writebacks below.
        do_issue(4'd3);
        do_issue(4'd8);
        do_issue(4'd1); do_issue(4'd1);
        do_issue(4'd2); do_issue(4'd2);
        do_issue(4'd4);
        do_issue(4'd6);

        // Single ALU write, one-cycle latency.
        wb_bus.alu_valid = 1'b1; wb_bus.alu_rd = 4'd3; wb_bus.alu_wd = 32'hDEADBEEF;
        #1 chk_ready("alu_single", 1'b0, 1'b1, 1'b0);
        push(4'd3, 32'hDEADBEEF);
        @(negedge clk);
        wb_bus.alu_valid = 1'b0;
        #1 chk("alu_single_wr", 32'(rf_wr_enable), 32'h1);
        @(negedge clk);
        #1 chk("alu_single_idle", 32'(rf_wr_enable), 32'h0);

        // Lone MEM write moves the pointer back to ALU-first.
        wb_bus.mem_valid = 1'b1; wb_bus.mem_rd = 4'd8; wb_bus.mem_wd = 32'h8888_0008;
        #1 chk_ready("mem_single", 1'b0, 1'b0, 1'b1);
        push(4'd8, 32'h8888_0008);
        @(negedge clk);
        wb_bus.mem_valid = 1'b0;

        // ALU and MEM contend continuously: strict alternation.
        wb_bus.alu_valid = 1'b1; wb_bus.alu_rd = 4'd1; wb_bus.alu_wd = 32'hA0;
        wb_bus.mem_valid = 1'b1; wb_bus.mem_rd = 4'd2; wb_bus.mem_wd = 32'hB0;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (k % 2 == 0) begin
                chk_ready("rr_alu", 1'b0, 1'b1, 1'b0);
                push(4'd1, wb_bus.alu_wd);
            end else begin
                chk_ready("rr_mem", 1'b0, 1'b0, 1'b1);
                push(4'd2, wb_bus.mem_wd);
            end
            @(negedge clk);
            if (k % 2 == 0) wb_bus.alu_wd = wb_bus.alu_wd + 32'h1;
            else            wb_bus.mem_wd = wb_bus.mem_wd + 32'h1;
        end
        wb_bus.alu_valid = 1'b0; wb_bus.mem_valid = 1'b0;

        // DBG preempts both; pointer unchanged by the DBG grant.
        wb_bus.dbg_valid = 1'b1; wb_bus.dbg_rd = 4'd10; wb_bus.dbg_wd = 32'hD0D0_000A;
        wb_bus.alu_valid = 1'b1; wb_bus.alu_rd = 4'd4;  wb_bus.alu_wd = 32'h4444_4444;
        wb_bus.mem_valid = 1'b1; wb_bus.mem_rd = 4'd6;  wb_bus.mem_wd = 32'h6666_6666;
        #1 chk_ready("dbg_prio", 1'b1, 1'b0, 1'b0);
        push(4'd10, 32'hD0D0_000A);
        @(negedge clk);
        wb_bus.dbg_valid = 1'b0;
        #1 chk_ready("after_dbg", 1'b0, 1'b1, 1'b0);
        push(4'd4, 32'h4444_4444);
        @(negedge clk);
        wb_bus.alu_valid = 1'b0;
        #1 chk_ready("after_alu", 1'b0, 1'b0, 1'b1);
        push(4'd6, 32'h6666_6666);
        @(negedge clk);
        wb_bus.mem_valid = 1'b0;

        // Hazard on rd=5 held through the write cycle.
        do_issue(4'd5);
        chk_rs2 = 4'd5;
        #1;
        chk("busy_r5", 32'(busy_mask), 32'h0000_0020);
        chk("hazard_set", 32'(hazard), 32'h1);
        wb_bus.alu_valid = 1'b1; wb_bus.alu_rd = 4'd5; wb_bus.alu_wd = 32'h5555_5555;
        #1 chk_ready("alu_r5", 1'b0, 1'b1, 1'b0);
        push(4'd5, 32'h5555_5555);
        @(negedge clk);
        wb_bus.alu_valid = 1'b0;
        #1;
        chk("r5_wr", 32'(rf_wr_enable), 32'h1);
        chk("hazard_in_wr", 32'(hazard), 32'h1);
        @(negedge clk);
        #1;
        chk("hazard_clear", 32'(hazard), 32'h0);
        chk("busy_clear", 32'(busy_mask), 32'h0);
        chk_rs2 = 4'd0;

        // Saturate pend[7], then a retire in the same cycle admits one more issue.
        do_issue(4'd7); do_issue(4'd7); do_issue(4'd7);
        issue_valid = 1'b1; issue_rd = 4'd7;
        wb_bus.alu_valid = 1'b1; wb_bus.alu_rd = 4'd7; wb_bus.alu_wd = 32'h7777_0000;
        #1;
        chk("stall_sat", 32'(issue_stall), 32'h1);
        chk("busy_r7", 32'(busy_mask), 32'h0000_0080);
        chk_ready("alu_r7", 1'b0, 1'b1, 1'b0);
        push(4'd7, 32'h7777_0000);
        @(negedge clk);
        wb_bus.alu_valid = 1'b0;
        #1;
        chk("r7_wr", 32'(rf_wr_enable), 32'h1);
        chk("stall_bypass", 32'(issue_stall), 32'h0);
        @(negedge clk);
        #1 chk("stall_still_sat", 32'(issue_stall), 32'h1);
        issue_valid = 1'b0;

        // Underflow on rd=9 sets the sticky error.
        chk("sb_error_clean", 32'(sb_error), 32'h0);
        wb_bus.mem_valid = 1'b1; wb_bus.mem_rd = 4'd9; wb_bus.mem_wd = 32'h9999_9999;
        #1 chk_ready("mem_r9", 1'b0, 1'b0, 1'b1);
        push(4'd9, 32'h9999_9999);
        @(negedge clk);
        wb_bus.mem_valid = 1'b0;
        #1 chk("sb_error_in_wr", 32'(sb_error), 32'h0);
        @(negedge clk);
        #1 chk("sb_error_set", 32'(sb_error), 32'h1);
        @(negedge clk);
        #1 chk("sb_error_held", 32'(sb_error), 32'h1);

        // Reset during a write cycle drops it and clears everything.
        wb_bus.alu_valid = 1'b1; wb_bus.alu_rd = 4'd7; wb_bus.alu_wd = 32'h7777_0001;
        #1 chk_ready("alu_pre_rst", 1'b0, 1'b1, 1'b0);
        push(4'd7, 32'h7777_0001);
        @(negedge clk);
        wb_bus.mem_valid = 1'b1; wb_bus.mem_rd = 4'd9;
        #1;
        chk("pre_rst_wr", 32'(rf_wr_enable), 32'h1);
        chk("pre_rst_busy", 32'(busy_mask), 32'h0000_0080);
        rst = 1'b1;
        #1;
        chk("mid_rst_wr", 32'(rf_wr_enable), 32'h0);
        chk("mid_rst_rd", 32'(rf_rd), 32'h0);
        chk("mid_rst_wd", rf_wd, 32'h0);
        chk("mid_rst_busy", 32'(busy_mask), 32'h0);
        chk("mid_rst_err", 32'(sb_error), 32'h0);
        chk_ready("mid_rst", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        wb_bus.alu_valid = 1'b0; wb_bus.mem_valid = 1'b0;
        rst = 1'b0;

        // Pointer returns to ALU-first after reset.
        do_issue(4'd0);
        do_issue(4'd9);
        wb_bus.alu_valid = 1'b1; wb_bus.alu_rd = 4'd0; wb_bus.alu_wd = 32'h0000_00A5;
        wb_bus.mem_valid = 1'b1; wb_bus.mem_rd = 4'd9; wb_bus.mem_wd = 32'h0000_0009;
        #1 chk_ready("post_rst_alu", 1'b0, 1'b1, 1'b0);
        push(4'd0, 32'h0000_00A5);
        @(negedge clk);
        wb_bus.alu_valid = 1'b0;
        #1 chk_ready("post_rst_mem", 1'b0, 1'b0, 1'b1);
        push(4'd9, 32'h0000_0009);
        @(negedge clk);
        wb_bus.mem_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("final_busy", 32'(busy_mask), 32'h0);
        chk("final_sb_error", 32'(sb_error), 32'h0);
        chk("writes_drained", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Shares the single register-file write port between three writeback sources: debug/loader (DBG), ALU and memory-load (MEM). Each source uses a valid/ready handshake.
- Contains a per-register pending-write scoreboard that drives read-hazard stalls for the issue stage.
- Sits between the execute/memory stages and the 16x32 register file, driving its write-enable, write-address and write-data inputs.

Parameters:
- NREG, 16, number of architectural registers.
- AW, 4, register address width; NREG = 2**AW.
- DW, 32, data width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- dbg_valid  in  1  debug write request
- dbg_rd  in  AW  debug destination register
- dbg_wd  in  DW  debug write data
- dbg_ready  out  1  debug request accepted this cycle
- alu_valid / alu_rd / alu_wd  in  1/AW/DW  ALU writeback request
- alu_ready  out  1  ALU request accepted
- mem_valid / mem_rd / mem_wd  in  1/AW/DW  load writeback request
- mem_ready  out  1  MEM request accepted
- issue_valid  in  1  an instruction writing issue_rd is issued this cycle
- issue_rd  in  AW  destination of the issued instruction
- issue_stall  out  1  issue_rd pending count saturated; issue must not fire
- chk_rs1, chk_rs2, chk_rs3  in  AW each  source registers of the instruction in decode
- hazard  out  1  at least one chk_rsN has a pending write
- rf_wr_enable  out  1  to register-file write enable
- rf_rd  out  AW  to register-file write address
- rf_wd  out  DW  to register-file write data
- busy_mask  out  NREG  bit r = 1 when pend[r] != 0
- sb_error  out  1  sticky scoreboard underflow flag

Behaviour:
- Reset (async): rf_wr_enable=0, rf_rd=0, rf_wd=0, all pend[]=0, busy_mask=0, sb_error=0, round-robin pointer = ALU-first. While rst=1, all readies are 0.
- Handshake: a transfer occurs when valid & ready. A source holds valid, rd and wd stable until ready. Readies are combinational from the valids and the arbiter state, and are one-hot or zero.
- Arbitration:
  - DBG has fixed highest priority.
  - ALU and MEM alternate round-robin among themselves. After an ALU grant the pointer moves to MEM-first; after a MEM grant it moves to ALU-first. A DBG grant leaves the pointer unchanged.
  - Continuous DBG traffic may starve ALU/MEM. This is permitted.
- Latency: 1 cycle. On the edge that accepts a request, rf_wr_enable<=1, rf_rd<=rd, rf_wd<=wd and src_tag<=source. With no transfer, rf_wr_enable<=0 and rf_rd/rf_wd hold their values. Back-to-back transfers produce one write every cycle.
- Scoreboard:
  - pend[r] is a 2-bit counter per register.
  - Increment: issue_valid & !issue_stall for issue_rd.
  - Decrement: rf_wr_enable=1 with src_tag in {ALU, MEM}, for rf_rd, on the edge ending the write cycle. The register file captures on that same edge.
  - DBG writes never change pend[].
  - Increment and decrement of the same register on the same edge: net unchanged.
  - Decrement with pend=0: pend stays 0 and sb_error<=1, held until reset.
  - issue_stall = (pend[issue_rd]==3) & !(decrement of issue_rd this cycle), combinational. issue_valid while issue_stall=1 is ignored.
- hazard = busy_mask[chk_rs1] | busy_mask[chk_rs2] | busy_mask[chk_rs3], combinational.
  - hazard stays asserted through the rf_wr_enable cycle and clears on the following cycle, when the written value is readable.
- No register is special-cased; every address 0..NREG-1 is written with the supplied data.
- Reset asserted mid-transfer: the pending rf write is dropped (rf_wr_enable=0 immediately) and the scoreboard is cleared.

Test Plan:
- Reset, then ALU request rd=3, wd=0xDEADBEEF -> alu_ready=1 in the same cycle; next cycle rf_wr_enable=1, rf_rd=3, rf_wd=0xDEADBEEF; the cycle after, rf_wr_enable=0.
- ALU and MEM valid continuously (ALU rd=1, MEM rd=2) for 4 cycles -> grants alternate ALU, MEM, ALU, MEM; rf_rd sequence 1,2,1,2.
- DBG, ALU and MEM all valid -> dbg_ready=1 only. DBG drops -> ALU granted (pointer untouched by DBG), then MEM.
- issue_valid rd=5 -> busy_mask[5]=1; chk_rs2=5 -> hazard=1. ALU writeback rd=5 -> hazard=1 during the rf_wr_enable cycle and 0 on the next cycle.
- Issue rd=7 three times -> pend=3 and issue_stall=1; a 4th issue is ignored. Same cycle as an ALU rd=7 write cycle -> issue_stall=0 and the issue is accepted, pend stays 3.
- MEM writeback to rd=9 with pend[9]=0 -> sb_error=1 and held. Assert rst mid-stream -> all outputs return to reset values asynchronously.
